// File: rtl/cmd_pkg.sv
// Shared definitions for the host command engine.
// Holds the command codes, the reply bytes, the status byte layout, the FSM
// state encoding and small sizing helpers.
package cmd_pkg;

  localparam logic [7:0] CMD_GET_SAMPLE = 8'h01;
  localparam logic [7:0] CMD_READ_CCD   = 8'h02;
  localparam logic [7:0] CMD_SHUTTER    = 8'h03;
  localparam logic [7:0] CMD_PELTIER    = 8'h04;
  localparam logic [7:0] CMD_STATUS     = 8'h05;

  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  // Status reply layout, MSB first: bit7 shutter, bit6 busy, bit5 overrun, bit4 timeout
  typedef struct packed {
    logic       shutter;
    logic       busy;
    logic       overrun;
    logic       timeout;
    logic [3:0] rsvd;
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ARG,
    S_EXEC,
    S_SEND,
    S_NAK,
    S_CCD_WAIT,
    S_CCD_STREAM,
    S_TRAILER
  } state_t;

  // Number of whole bytes needed to carry a value of the given bit width
  function automatic int unsigned bytes_for(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

  function automatic logic is_cmd(input logic [7:0] code);
    return (code >= CMD_GET_SAMPLE) && (code <= CMD_STATUS);
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Parallel-to-byte serializer with a valid/ready byte output.
// A load captures a word and a byte count; bytes leave MSB first, one per
// accepted transfer, with no gap between bytes of the same word.
// Ports: clk, rst_n; i_load/i_word/i_len load request; o_data/o_valid/i_ready
// byte handshake; o_empty when nothing is queued; o_last on the final byte.
module byte_serializer #(
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned LEN_W      = $clog2(WORD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_load,
  input  logic [WORD_BYTES*8-1:0] i_word,
  input  logic [LEN_W-1:0]        i_len,
  output logic [7:0]              o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_empty,
  output logic                    o_last
);

  localparam int unsigned W_BITS = WORD_BYTES * 8;

  logic [W_BITS-1:0] r_shift;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_valid;

  // Left-align the word on load so the top byte is always the next to send
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= W_BITS'(i_word << ((WORD_BYTES - 32'(i_len)) * 32'd8));
      r_cnt   <= i_len;
      r_valid <= (i_len != '0);
    end else if (r_valid && i_ready) begin
      r_shift <= r_shift << 8;
      r_cnt   <= r_cnt - LEN_W'(1);
      r_valid <= (r_cnt != LEN_W'(1));
    end
  end

  assign o_data  = r_shift[W_BITS-1 -: 8];
  assign o_valid = r_valid;
  assign o_empty = ~r_valid;
  assign o_last  = (r_cnt == LEN_W'(1));

endmodule

// File: rtl/cmd_controller.sv
// Host command engine between the FT245 byte interface and camera peripherals.
// Parses two-byte commands, returns sensor samples, drives CCD frame readout
// with a pixel-count trailer, and holds shutter/peltier settings.
// Ports: clk, rst_n; rx_data/rx_valid host bytes in; tx_data/tx_valid/tx_ready
// reply bytes out; sample_bus sensor channels; ccd_start/ccd_mode/ccd_busy
// frame control; pix_data/pix_valid/pix_ready pixel stream; shutter_open and
// peltier_duty held settings.
module cmd_controller
  import cmd_pkg::*;
#(
  parameter int unsigned N_CH      = 8,
  parameter int unsigned SAMPLE_W  = 10,
  parameter int unsigned PIX_W     = 16,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [N_CH*SAMPLE_W-1:0] sample_bus,
  output logic                     ccd_start,
  output logic [1:0]               ccd_mode,
  input  logic                     ccd_busy,
  input  logic [PIX_W-1:0]         pix_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic                     shutter_open,
  output logic [7:0]               peltier_duty
);

  localparam int unsigned S_BYTES    = bytes_for(SAMPLE_W);
  localparam int unsigned P_BYTES    = bytes_for(PIX_W);
  localparam int unsigned SP_BYTES   = (S_BYTES > P_BYTES) ? S_BYTES : P_BYTES;
  localparam int unsigned WORD_BYTES = (SP_BYTES > 32'd2) ? SP_BYTES : 32'd2;
  localparam int unsigned WORD_W     = WORD_BYTES * 8;
  localparam int unsigned LEN_W      = $clog2(WORD_BYTES + 1);

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_cmd, r_arg;
  logic [TIMEOUT_W-1:0]  r_to_cnt;
  logic                  r_timeout, r_overrun, r_stat_clr;
  logic                  r_shutter, r_ccd_start, r_pix_ready;
  logic [7:0]            r_peltier;
  logic [1:0]            r_ccd_mode;
  logic [15:0]           r_pix_cnt;
  logic                  r_ld;
  logic [WORD_W-1:0]     r_ld_word;
  logic [LEN_W-1:0]      r_ld_len;

  logic                  w_ld_req, w_dir_ld;
  logic [WORD_W-1:0]     w_ld_word, w_dir_word, w_ser_word;
  logic [LEN_W-1:0]      w_ld_len, w_dir_len, w_ser_len;
  logic                  w_latch_cmd, w_latch_arg, w_to_expire, w_stat_req;
  logic                  w_exec_shutter, w_exec_peltier, w_exec_ccd;
  logic                  w_ser_load, w_ser_valid, w_ser_empty, w_ser_last;
  logic                  w_ser_empty_nxt, w_pix_acc, w_stat_clr, w_rx_drop, w_ch_ok;
  logic [7:0]            w_ser_data;
  logic [SAMPLE_W-1:0]   w_sample;
  status_t               w_status;

  // Selected sensor channel; only meaningful when the channel is in range
  always_comb begin
    w_sample = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (32'(r_arg) == 32'(c)) w_sample = sample_bus[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  assign w_ch_ok    = (32'(r_arg) < N_CH);
  assign w_status   = {r_shutter, ccd_busy, r_overrun, r_timeout, 4'b0};
  assign w_pix_acc  = r_pix_ready && pix_valid;
  assign w_stat_clr = r_stat_clr && w_ser_valid && tx_ready;
  assign w_rx_drop  = rx_valid && (r_state != S_IDLE) && (r_state != S_GET_ARG);

  // Command replies load one cycle after EXEC; pixels and trailer load directly
  assign w_ser_load = r_ld | w_dir_ld;
  assign w_ser_word = w_dir_ld ? w_dir_word : r_ld_word;
  assign w_ser_len  = w_dir_ld ? w_dir_len  : r_ld_len;

  // Serializer will be empty next cycle: lets pix_ready be a registered output
  assign w_ser_empty_nxt = !w_ser_load &&
                           (w_ser_empty || (w_ser_valid && tx_ready && w_ser_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_req       = 1'b0;
    w_ld_word      = '0;
    w_ld_len       = '0;
    w_dir_ld       = 1'b0;
    w_dir_word     = '0;
    w_dir_len      = '0;
    w_latch_cmd    = 1'b0;
    w_latch_arg    = 1'b0;
    w_to_expire    = 1'b0;
    w_stat_req     = 1'b0;
    w_exec_shutter = 1'b0;
    w_exec_peltier = 1'b0;
    w_exec_ccd     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (is_cmd(rx_data)) begin
            w_latch_cmd = 1'b1;
            w_state_nxt = S_GET_ARG;
          end else begin
            w_ld_req    = 1'b1;
            w_ld_word   = WORD_W'(NAK_BYTE);
            w_ld_len    = LEN_W'(1);
            w_state_nxt = S_NAK;
          end
        end
      end
      S_GET_ARG: begin
        // An arriving byte beats a simultaneous expiry
        if (rx_valid) begin
          w_latch_arg = 1'b1;
          w_state_nxt = S_EXEC;
        end else if (r_to_cnt == '1) begin
          w_to_expire = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        w_ld_req    = 1'b1;
        w_ld_len    = LEN_W'(1);
        w_ld_word   = WORD_W'(ACK_BYTE);
        w_state_nxt = S_SEND;
        case (r_cmd)
          CMD_GET_SAMPLE: begin
            if (w_ch_ok) begin
              w_ld_word = WORD_W'(w_sample);
              w_ld_len  = LEN_W'(S_BYTES);
            end else begin
              w_ld_word   = WORD_W'(NAK_BYTE);
              w_state_nxt = S_NAK;
            end
          end
          CMD_SHUTTER: w_exec_shutter = 1'b1;
          CMD_PELTIER: w_exec_peltier = 1'b1;
          CMD_STATUS: begin
            w_ld_word  = WORD_W'(w_status);
            w_stat_req = 1'b1;
          end
          CMD_READ_CCD: begin
            w_ld_req    = 1'b0;
            w_exec_ccd  = 1'b1;
            w_state_nxt = S_CCD_WAIT;
          end
          default: begin
            w_ld_req    = 1'b0;
            w_state_nxt = S_IDLE;
          end
        endcase
      end
      S_SEND, S_NAK: begin
        if (!r_ld && w_ser_empty) w_state_nxt = S_IDLE;
      end
      S_CCD_WAIT: begin
        if (ccd_busy) w_state_nxt = S_CCD_STREAM;
      end
      S_CCD_STREAM: begin
        if (w_pix_acc) begin
          w_dir_ld   = 1'b1;
          w_dir_word = WORD_W'(pix_data);
          w_dir_len  = LEN_W'(P_BYTES);
        end else if (!ccd_busy && !pix_valid && w_ser_empty) begin
          w_dir_ld    = 1'b1;
          w_dir_word  = WORD_W'(r_pix_cnt);
          w_dir_len   = LEN_W'(2);
          w_state_nxt = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (w_ser_empty) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers, flags and held settings
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_arg       <= '0;
      r_to_cnt    <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
      r_stat_clr  <= 1'b0;
      r_shutter   <= 1'b0;
      r_peltier   <= '0;
      r_ccd_mode  <= '0;
      r_ccd_start <= 1'b0;
      r_pix_cnt   <= '0;
      r_pix_ready <= 1'b0;
      r_ld        <= 1'b0;
      r_ld_word   <= '0;
      r_ld_len    <= '0;
    end else begin
      r_ld      <= w_ld_req;
      r_ld_word <= w_ld_word;
      r_ld_len  <= w_ld_len;
      if (w_latch_cmd) r_cmd <= rx_data;
      if (w_latch_arg) r_arg <= rx_data;
      if (w_latch_cmd)                r_to_cnt <= '0;
      else if (r_state == S_GET_ARG)  r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
      // New events after the status snapshot survive the clear
      r_timeout <= (r_timeout & ~w_stat_clr) | w_to_expire;
      r_overrun <= (r_overrun & ~w_stat_clr) | w_rx_drop;
      if (w_stat_req)      r_stat_clr <= 1'b1;
      else if (w_stat_clr) r_stat_clr <= 1'b0;
      if (w_exec_shutter) r_shutter <= r_arg[0];
      if (w_exec_peltier) r_peltier <= r_arg;
      if (w_exec_ccd)     r_ccd_mode <= r_arg[1:0];
      r_ccd_start <= w_exec_ccd;
      if (w_exec_ccd)     r_pix_cnt <= '0;
      else if (w_pix_acc) r_pix_cnt <= r_pix_cnt + 16'd1;
      r_pix_ready <= (w_state_nxt == S_CCD_STREAM) && w_ser_empty_nxt;
    end
  end

  byte_serializer #(
    .WORD_BYTES(WORD_BYTES),
    .LEN_W     (LEN_W)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_ser_load),
    .i_word (w_ser_word),
    .i_len  (w_ser_len),
    .o_data (w_ser_data),
    .o_valid(w_ser_valid),
    .i_ready(tx_ready),
    .o_empty(w_ser_empty),
    .o_last (w_ser_last)
  );

  assign tx_data      = w_ser_data;
  assign tx_valid     = w_ser_valid;
  assign ccd_start    = r_ccd_start;
  assign ccd_mode     = r_ccd_mode;
  assign pix_ready    = r_pix_ready;
  assign shutter_open = r_shutter;
  assign peltier_duty = r_peltier;

endmodule

// File: tb/tb_cmd_controller.sv
// Directed bench for cmd_controller with a reply-byte scoreboard.
module tb_cmd_controller;

  localparam int unsigned N_CH      = 8;
  localparam int unsigned SAMPLE_W  = 10;
  localparam int unsigned PIX_W     = 16;
  localparam int unsigned TIMEOUT_W = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [N_CH*SAMPLE_W-1:0] sample_bus;
  logic                     ccd_start;
  logic [1:0]               ccd_mode;
  logic                     ccd_busy;
  logic [PIX_W-1:0]         pix_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic                     shutter_open;
  logic [7:0]               peltier_duty;

  always #5 clk = ~clk;

  cmd_controller #(
    .N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .PIX_W(PIX_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sample_bus(sample_bus),
    .ccd_start(ccd_start), .ccd_mode(ccd_mode), .ccd_busy(ccd_busy),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .shutter_open(shutter_open), .peltier_duty(peltier_duty)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          ready_mode = 0;   // 0: always ready, 1: random stalls, 2: stalled
  bit          hold_pending = 1'b0;
  logic [7:0]  hold_data = 8'h00;
  int          start_cnt = 0;
  bit          streaming = 1'b0;
  bit          pix_taken = 1'b0;
  int          pix_idx = 0;
  logic [15:0] pix_mem [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, monitor the byte handshake
  task automatic tick();
    @(negedge clk);
    if (pix_taken) begin
      pix_idx++;
      pix_taken = 1'b0;
    end
    pix_valid = streaming && (pix_idx < 3);
    pix_data  = (pix_idx < 3) ? pix_mem[pix_idx] : 16'h0000;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 2) != 0);
      default: tx_ready = 1'b0;
    endcase
    if (ccd_start) start_cnt++;
    if (pix_valid && pix_ready) pix_taken = 1'b1;
    if (pix_ready) chk("pix_ready_while_tx", 32'(tx_valid), 32'd0);
    if (hold_pending) begin
      chk("tx_valid_hold", 32'(tx_valid), 32'd1);
      chk("tx_data_hold", 32'(tx_data), 32'(hold_data));
    end
    if (tx_valid && tx_ready) begin
      chk("tx_unexpected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      hold_pending = 1'b0;
    end else if (tx_valid) begin
      hold_pending = 1'b1;
      hold_data    = tx_data;
    end else begin
      hold_pending = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (4) tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_valid"},  32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"},   32'(tx_data), 32'd0);
    chk({tag, "_ccd_start"}, 32'(ccd_start), 32'd0);
    chk({tag, "_ccd_mode"},  32'(ccd_mode), 32'd0);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
    chk({tag, "_shutter"},   32'(shutter_open), 32'd0);
    chk({tag, "_peltier"},   32'(peltier_duty), 32'd0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;
    ccd_busy  = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 16'h0000;
    pix_mem[0] = 16'h1234;
    pix_mem[1] = 16'hABCD;
    pix_mem[2] = 16'h0001;
    for (int c = 0; c < int'(N_CH); c++) sample_bus[c*SAMPLE_W +: SAMPLE_W] = 10'(c * 37 + 5);
    sample_bus[3*SAMPLE_W +: SAMPLE_W] = 10'h2A5;
    sample_bus[7*SAMPLE_W +: SAMPLE_W] = 10'h3C7;

    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // GET_SAMPLE channel 3 with reply latency
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hA5);
    send_byte(8'h01);
    send_byte(8'h03);
    chk("lat_exec", 32'(tx_valid), 32'd0);
    tick();
    chk("lat_1", 32'(tx_valid), 32'd0);
    tick();
    chk("lat_2", 32'(tx_valid), 32'd1);
    drain(50);

    // Out-of-range channel and unknown code
    exp_q.push_back(8'hEE);
    send_byte(8'h01);
    send_byte(8'h09);
    drain(50);
    exp_q.push_back(8'hEE);
    send_byte(8'h7F);
    drain(50);
    chk("nak_shutter", 32'(shutter_open), 32'd0);
    chk("nak_peltier", 32'(peltier_duty), 32'd0);
    chk("nak_mode",    32'(ccd_mode), 32'd0);

    // Argument arriving on the expiry cycle is taken
    exp_q.push_back(8'hAA);
    send_byte(8'h04);
    repeat ((1 << TIMEOUT_W) - 1) tick();
    send_byte(8'h40);
    drain(50);
    chk("race_peltier", 32'(peltier_duty), 32'h40);

    // Timeout with no reply
    send_byte(8'h04);
    repeat ((1 << TIMEOUT_W) + 4) tick();
    chk("timeout_peltier", 32'(peltier_duty), 32'h40);

    // Overrun while a reply is stalled
    ready_mode = 2;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hA5);
    send_byte(8'h01);
    send_byte(8'h03);
    repeat (4) tick();
    chk("stall_valid", 32'(tx_valid), 32'd1);
    send_byte(8'h55);
    repeat (2) tick();
    ready_mode = 0;
    drain(50);

    // STATUS reports and clears the sticky flags
    exp_q.push_back(8'h30);
    send_byte(8'h05);
    send_byte(8'h00);
    drain(50);
    exp_q.push_back(8'h00);
    send_byte(8'h05);
    send_byte(8'h00);
    drain(50);

    // Shutter and peltier settings
    exp_q.push_back(8'hAA);
    send_byte(8'h03);
    send_byte(8'h01);
    drain(50);
    exp_q.push_back(8'hAA);
    send_byte(8'h04);
    send_byte(8'h80);
    drain(50);
    chk("shutter_set", 32'(shutter_open), 32'd1);
    chk("peltier_set", 32'(peltier_duty), 32'h80);

    // CCD frame with random stalls and count trailer
    start_cnt = 0;
    send_byte(8'h02);
    send_byte(8'h01);
    chk("ccd_start_exec", 32'(ccd_start), 32'd0);
    tick();
    chk("ccd_start_pulse", 32'(ccd_start), 32'd1);
    chk("ccd_mode", 32'(ccd_mode), 32'd1);
    tick();
    chk("ccd_start_drop", 32'(ccd_start), 32'd0);
    repeat (3) tick();
    chk("ccd_wait_idle_tx", 32'(tx_valid), 32'd0);
    foreach (pix_mem[i]) begin
      exp_q.push_back(pix_mem[i][15:8]);
      exp_q.push_back(pix_mem[i][7:0]);
    end
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h03);
    pix_idx    = 0;
    ready_mode = 1;
    ccd_busy   = 1'b1;
    streaming  = 1'b1;
    n = 0;
    while (pix_idx < 3 && n < 500) begin
      tick();
      n++;
    end
    chk("pix_consumed", 32'(pix_idx), 32'd3);
    ccd_busy  = 1'b0;
    streaming = 1'b0;
    drain(500);
    ready_mode = 0;
    chk("ccd_start_count", 32'(start_cnt), 32'd1);

    // Asynchronous reset in the middle of a stalled pixel
    send_byte(8'h02);
    send_byte(8'h02);
    ccd_busy = 1'b1;
    repeat (3) tick();
    chk("stream_pix_ready", 32'(pix_ready), 32'd1);
    ready_mode = 2;
    pix_idx    = 0;
    streaming  = 1'b1;
    repeat (4) tick();
    chk("stream_mid_valid", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    streaming    = 1'b0;
    ccd_busy     = 1'b0;
    pix_taken    = 1'b0;
    hold_pending = 1'b0;
    ready_mode   = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_tx_valid", 32'(tx_valid), 32'd0);

    // Normal operation after reset
    exp_q.push_back(8'h03);
    exp_q.push_back(8'hC7);
    send_byte(8'h01);
    send_byte(8'h07);
    drain(50);
    chk("post_rst_mode", 32'(ccd_mode), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_controller.md
# cmd_controller

Parametrised host-command engine between the synchronous FT245 byte interface and the camera peripherals. It parses command and argument bytes and returns N-channel sensor samples of any width as MSB-first byte words. It starts CCD frames and streams pixels with a count trailer, and it holds the shutter and peltier settings. It replaces the hard-wired top-level state machine with one that covers width, channel count, argument timeouts and error replies.

## Interface
- `N_CH`, 8: number of sensor channels on `sample_bus`.
- `SAMPLE_W`, 10: bits per sensor sample; sent as S_BYTES = ceil(SAMPLE_W/8) bytes.
- `PIX_W`, 16: bits per CCD pixel; sent as P_BYTES = ceil(PIX_W/8) bytes.
- `TIMEOUT_W`, 16: width of the argument-timeout counter; timeout = 2^TIMEOUT_W-1 cycles.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `rx_data` in 8: byte from the FT245 interface.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid.
- `tx_data` out 8: byte to the FT245 interface.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the byte transfers on a clk edge with `tx_valid` and `tx_ready` both high.
- `sample_bus` in N_CH*SAMPLE_W: latest conversions; channel c is at [c*SAMPLE_W +: SAMPLE_W].
- `ccd_start` out 1: one-cycle frame start pulse.
- `ccd_mode` out 2: readout mode; registered and held.
- `ccd_busy` in 1: high while a frame is being read out.
- `pix_data` in PIX_W: pixel word.
- `pix_valid` in 1: pixel available.
- `pix_ready` out 1: pixel consumed when high together with `pix_valid`.
- `shutter_open` out 1: shutter command level.
- `peltier_duty` out 8: peltier PWM duty.

Reset: all outputs 0. State is IDLE and all flags are clear.

## Operation
- Command codes (all 2-byte: cmd, arg): GET_SAMPLE 0x01 (arg = channel), READ_CCD 0x02 (arg[1:0] = mode), SHUTTER 0x03 (arg[0]), PELTIER 0x04 (arg = duty), STATUS 0x05 (arg ignored).
- IDLE:
  - Known code on `rx_valid`: latch it, go to GET_ARG.
  - Unknown code: go to NAK.
- GET_ARG:
  - Argument byte: go to EXEC.
  - Counter reaches 2^TIMEOUT_W-1 with no argument: set `timeout_flag`, go to IDLE. No reply.
- EXEC, by command:
  - GET_SAMPLE with ch < N_CH: load the channel zero-extended to S_BYTES*8, go to SEND with S_BYTES bytes.
  - GET_SAMPLE with ch ≥ N_CH: go to NAK.
  - SHUTTER or PELTIER: update the register, send ACK 0xAA.
  - STATUS: send {shutter_open, ccd_busy, overrun, timeout_flag, 4'b0}, then clear `overrun` and `timeout_flag` on transfer.
  - READ_CCD: set `ccd_mode`, pulse `ccd_start`, go to CCD_WAIT.
- SEND: shift register, MSB byte first. Byte counter decrements per transfer. Return to IDLE after the last byte.
- NAK: send 0xEE, then IDLE.
- CCD_WAIT: on `ccd_busy`=1, go to CCD_STREAM.
- CCD_STREAM:
  - `pix_ready`=1 only when the shift register is empty.
  - Each pixel is sent as P_BYTES bytes, MSB first. A 16-bit pixel counter increments per pixel and wraps mod 2^16.
  - When `ccd_busy`=0, `pix_valid`=0 and the shift register is empty: go to TRAILER.
- TRAILER: send the pixel count MSB then LSB, then IDLE.
- Overrun: an `rx_valid` outside IDLE/GET_ARG drops the byte and sets sticky `overrun`.

## Timing
- `tx_valid` rises 2 cycles after the edge that consumes the argument byte. EXEC takes 1 cycle.
- Once `tx_valid`=1, `tx_data` is held until transfer. `tx_valid` never drops before transfer.
- Back-to-back transfers: the next byte is valid the cycle after transfer (zero bubbles within a word).
- CCD stream: a pixel is accepted in the cycle after the previous pixel's last byte transfers, so there is a 1-cycle bubble between pixels.
- `ccd_start` is high exactly one cycle, the cycle after EXEC.
- Simultaneous `rx_valid` and timeout expiry in GET_ARG: the byte wins; no timeout.
- Asynchronous reset mid-transfer: `tx_valid` and `pix_ready` drop immediately. No partial word resumes.

## Structure
- Package `cmd_pkg`: command codes, ACK/NAK values, status bit positions, state enum.
- One sub-module `byte_serializer`:
  - parameter WORD_BYTES
  - load word + length
  - valid/ready byte output
  - `empty` flag
- It is shared by SEND, CCD_STREAM and TRAILER. The top level holds the FSM, timeout counter, flags and registers.

## Test plan
- N_CH=8, SAMPLE_W=10, ch3=0x2A5; send 0x01,0x03 with `tx_ready`=1 → tx 0x02, 0x A5; first `tx_valid` 2 cycles after arg; IDLE.
- Send 0x01,0x09 → tx 0xEE; send 0x7F → tx 0xEE; no other outputs change.
- Send 0x03,0x01 then 0x04,0x80 → 0xAA twice; `shutter_open`=1; `peltier_duty`=0x80.
- Send 0x02,0x01. Source gives 3 pixels 0x1234, 0xABCD, 0x0001 with random `tx_ready` stalls, then `ccd_busy`=0. Response:
  - `ccd_mode`=1, one `ccd_start` pulse.
  - tx 12 34 AB CD 00 01 00 03.
  - `tx_data` stable during stalls.
- Send 0x04 only, wait 2^TIMEOUT_W cycles. Then, while a 2-byte reply is stalled, inject an rx byte. Then send 0x05,0x00 → status byte 0x30. A second STATUS → 0x00.
- Assert `rst_n`=0 during the CCD stream → all outputs 0 asynchronously. After release, GET_SAMPLE works normally.
